// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth triplet {b[2j+1], b[2j], b[2j-1]} codes
  localparam logic [2:0] TRI_ZERO_LO = 3'b000;
  localparam logic [2:0] TRI_POS1_A  = 3'b001;
  localparam logic [2:0] TRI_POS1_B  = 3'b010;
  localparam logic [2:0] TRI_POS2    = 3'b011;
  localparam logic [2:0] TRI_NEG2    = 3'b100;
  localparam logic [2:0] TRI_NEG1_A  = 3'b101;
  localparam logic [2:0] TRI_NEG1_B  = 3'b110;
  localparam logic [2:0] TRI_ZERO_HI = 3'b111;

  typedef struct packed {
    logic neg;
    logic single;
    logic dbl;
  } booth_sel_t;

  function automatic booth_sel_t booth_encode(input logic [2:0] triplet);
    booth_sel_t sel;
    sel = '0;
    unique case (triplet)
      TRI_ZERO_LO, TRI_ZERO_HI: sel = '0;
      TRI_POS1_A, TRI_POS1_B:   sel = '{neg: 1'b0, single: 1'b1, dbl: 1'b0};
      TRI_POS2:                 sel = '{neg: 1'b0, single: 1'b0, dbl: 1'b1};
      TRI_NEG2:                 sel = '{neg: 1'b1, single: 1'b0, dbl: 1'b1};
      TRI_NEG1_A, TRI_NEG1_B:   sel = '{neg: 1'b1, single: 1'b1, dbl: 1'b0};
      default:                  sel = '0;
    endcase
    return sel;
  endfunction

  function automatic int unsigned ndig(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic int unsigned ncyc(input int unsigned width, input int unsigned dpc);
    return ndig(width) / dpc;
  endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// One radix-4 Booth digit: selects +/-A, +/-2A or 0 as a sign-extended
// partial product in ones'-complement form plus the matching +1 bit.
module booth_digit_pp
  import booth_pkg::*;
#(
  parameter int unsigned EW = 12
) (
  input  logic [2:0]      triplet,
  input  logic [EW-1:0]   a,
  output logic [2*EW-1:0] pp_c,
  output logic            comp_c
);

  booth_sel_t      sel;
  logic [EW:0]     mag;

  always_comb begin
    sel    = booth_encode(triplet);
    mag    = '0;
    comp_c = sel.neg & (sel.single | sel.dbl);
    if (sel.dbl)         mag = {a, 1'b0};
    else if (sel.single) mag = {a[EW-1], a};
    // Only nonzero digits are inverted so a zero digit contributes exactly 0
    if (comp_c)          mag = ~mag;
    pp_c = {{(EW-1){mag[EW]}}, mag};
  end

endmodule

// File: rtl/booth_mult_iter.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per
// clock, with valid/ready handshakes on the operand and product sides.
module booth_mult_iter
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH            = 11,
  parameter int unsigned DIGITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int unsigned DPC  = DIGITS_PER_CYCLE;
  localparam int unsigned NDIG = ndig(WIDTH);
  localparam int unsigned EW   = 2 * NDIG;
  localparam int unsigned NCYC = ncyc(WIDTH, DPC);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned AW   = 2 * EW;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if ((DPC == 0) || (NDIG % DPC != 0)) begin : g_bad_dpc
    $error("booth_mult_iter: DIGITS_PER_CYCLE must divide the Booth digit count");
  end

  state_e          state_q, state_d;
  logic [EW-1:0]   a_q, b_q;
  logic            b_prev_q;
  logic [AW-1:0]   acc_q, acc_sum;
  logic [CW-1:0]   cnt_q;
  logic            accept;
  logic [AW-1:0]   pp   [DPC];
  logic            comp [DPC];
  logic [AW-1:0]   term;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_prod = acc_q[PW-1:0];

  for (genvar g = 0; g < int'(DPC); g++) begin : g_digit
    logic [2:0] triplet;
    if (g == 0) begin : g_low
      assign triplet = {b_q[1:0], b_prev_q};
    end else begin : g_mid
      assign triplet = b_q[2*g+1 -: 3];
    end
    booth_digit_pp #(.EW(EW)) u_pp (
      .triplet (triplet),
      .a       (a_q),
      .pp_c    (pp[g]),
      .comp_c  (comp[g])
    );
  end

  // Sum this cycle's digits into the accumulator at their absolute offsets
  always_comb begin
    acc_sum = acc_q;
    term    = '0;
    for (int j = 0; j < int'(DPC); j++) begin
      term    = pp[j] + AW'(comp[j]);
      acc_sum = acc_sum + (term << (2 * (32'(cnt_q) * DPC + 32'(j))));
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = in_valid & in_ready & ~clear;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = RUN;
        RUN:  if (cnt_q == CW'(NCYC - 1)) state_d = DONE;
        DONE: begin
          if (accept)         state_d = RUN;
          else if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      b_prev_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        a_q      <= {{(EW-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
        b_q      <= {{(EW-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
        b_prev_q <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        acc_q    <= acc_sum;
        b_q      <= EW'($signed(b_q) >>> (2 * DPC));
        b_prev_q <= b_q[2*DPC-1];
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_iter.sv
// Bench for booth_mult_iter: one instance at one digit per cycle, one at two,
// both checked against an integer-multiply reference.
module tb_booth_mult_iter;

  localparam int unsigned W    = 11;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned NDIG = W / 2 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_a      [2];
  logic [W-1:0]  in_b      [2];
  logic          in_signed [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [PW-1:0] out_prod  [2];
  logic          busy      [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mult_iter #(.WIDTH(W), .DIGITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .in_signed(in_signed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_prod(out_prod[0]), .busy(busy[0])
  );

  booth_mult_iter #(.WIDTH(W), .DIGITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .in_signed(in_signed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_prod(out_prod[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return PW'(x * y);
  endfunction

  function automatic int ncyc_of(input int k);
    return (k == 0) ? int'(NDIG) : int'(NDIG / 2);
  endfunction

  // Present operands at a falling edge; returns at the falling edge after the accept
  task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    check("in_ready_at_issue", in_ready[k], 1'b1);
    in_valid[k]  = 1'b1;
    in_a[k]      = a;
    in_b[k]      = b;
    in_signed[k] = s;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Accept edge counts as edge 1; product must be visible after edge NCYC+1
  task automatic wait_done(input int k, input logic [PW-1:0] exp, input string tag);
    int lat;
    lat = 1;
    while (!out_valid[k] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'(ncyc_of(k) + 1));
    check({tag, "_prod"}, out_prod[k], exp);
  endtask

  initial begin
    logic        ok;
    logic [W-1:0] ra, rb;
    logic        rs;

    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0;
      in_signed[k] = 1'b0; out_ready[k] = 1'b1;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", in_ready[k], 1'b1);
      check("rst_out_valid", out_valid[k], 1'b0);
      check("rst_busy", busy[k], 1'b0);
      check("rst_out_prod", out_prod[k], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 11'd2047, 11'd2047, 1'b0); wait_done(0, 22'd4190209, "umax");
    issue(0, 11'h400, 11'h400, 1'b1);   wait_done(0, 22'd1048576, "smin");
    issue(0, 11'h7FF, 11'd5, 1'b1);     wait_done(0, 22'h3FFFFB, "sneg1x5");
    issue(0, 11'd0, 11'd1234, 1'b0);    wait_done(0, 22'd0, "zero_a");
    issue(0, 11'd2047, 11'd0, 1'b0);    wait_done(0, 22'd0, "zero_b");

    // Back-pressure: product held, no new operands taken
    issue(0, 11'd123, 11'd45, 1'b0);
    out_ready[0] = 1'b0;
    wait_done(0, 22'd5535, "bp");
    in_valid[0] = 1'b1; in_a[0] = 11'd7; in_b[0] = 11'd7;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      ok &= out_valid[0] & (out_prod[0] == 22'd5535) & ~in_ready[0];
    end
    check("bp_hold", ok, 1'b1);
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release_valid", out_valid[0], 1'b0);
    check("bp_release_busy", busy[0], 1'b0);
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      ok &= ~out_valid[0];
    end
    check("bp_taken_once", ok, 1'b1);

    // Back-to-back: second accept on the edge that drains the first product
    issue(0, 11'd3, 11'd7, 1'b0); wait_done(0, 22'd21, "b2b_first");
    issue(0, 11'd5, 11'd9, 1'b0);
    check("b2b_no_gap_busy", busy[0], 1'b1);
    check("b2b_valid_drop", out_valid[0], 1'b0);
    wait_done(0, 22'd45, "b2b_second");

    // Abort in the third RUN cycle
    issue(0, 11'd100, 11'd200, 1'b0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    clear[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    clear[0] = 1'b0;
    check("clr_busy", busy[0], 1'b0);
    check("clr_out_valid", out_valid[0], 1'b0);
    check("clr_out_prod", out_prod[0], '0);
    check("clr_in_ready", in_ready[0], 1'b1);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      ok &= ~out_valid[0];
    end
    check("clr_no_result", ok, 1'b1);
    issue(0, 11'd0, 11'd1234, 1'b0); wait_done(0, 22'd0, "after_clr");

    // Asynchronous reset in the middle of RUN
    issue(0, 11'd1000, 11'd1000, 1'b0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid[0], 1'b0);
    check("arst_busy", busy[0], 1'b0);
    check("arst_in_ready", in_ready[0], 1'b1);
    check("arst_out_prod", out_prod[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 11'd77, 11'h788, 1'b1); wait_done(0, ref_prod(11'd77, 11'h788, 1'b1), "after_arst");

    // Random operands, back-to-back, against the integer reference
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < ((k == 0) ? 60 : 500); n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom);
        if (n % 17 == 0) ra = rs ? 11'h400 : 11'h7FF;
        if (n % 23 == 0) rb = rs ? 11'h400 : 11'h7FF;
        issue(k, ra, rb, rs);
        wait_done(k, ref_prod(ra, rb, rs), (k == 0) ? "rnd_dpc1" : "rnd_dpc2");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
